pipe_hazard_scb: RTL and testbench
==================================

PIPE_HAZARD_SCB -- requirements
Module: pipe_hazard_scb

Interface
REQ-001 Parameter REGW, default 5: register-index width; NREG = 2**REGW.
REQ-002 Parameter FLUSH_CYC, default 1: cycles flush is held after an exception (legal range 1..15).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rs_d, rt_d  in  REGW  D-stage source indices; use_rs_d, use_rt_d, branch_d  in  1.
REQ-006 rs_e, rt_e, wreg_e  in  REGW; regwrite_e, memtoreg_e  in  1  E-stage info.
REQ-007 wreg_m  in  REGW; regwrite_m, memtoreg_m  in  1  M-stage info.
REQ-008 wreg_w  in  REGW; regwrite_w  in  1  W-stage info.
REQ-009 lat_issue  in  1, lat_wreg  in  REGW  long-latency op (divider) leaves E targeting lat_wreg.
REQ-010 lat_done  in  1, lat_dreg  in  REGW  long-latency result written to lat_dreg this cycle.
REQ-011 div_busy  in  1  divider occupied; except_m  in  1  exception taken in M.
REQ-012 stall_f, stall_d, stall_e  out  1; flush_f, flush_d, flush_e, flush_m, flush_w  out  1.
REQ-013 fwd_a_d, fwd_b_d  out  1  M->D forward; fwd_a_e, fwd_b_e  out  2  (00 regfile, 10 from M, 01 from W).
REQ-014 scb_busy  out  1  any scoreboard bit set; flushing  out  1  flush FSM not in RUN.

Function
REQ-015 Register 0 shall never forward, stall or be scoreboarded.
REQ-016 fwd_a_e shall be 10 when rs_e==wreg_m and regwrite_m, else 01 when rs_e==wreg_w and regwrite_w, else 00; fwd_b_e likewise on rt_e; M priority over W.
REQ-017 fwd_a_d/fwd_b_d shall be 1 when rs_d/rt_d equals wreg_m with regwrite_m and not memtoreg_m.
REQ-018 Load-use stall: memtoreg_e and wreg_e nonzero and wreg_e matches a used D source.
REQ-019 Branch stall: branch_d and (regwrite_e with wreg_e matching a used D source, or memtoreg_m with wreg_m matching).
REQ-020 Scoreboard: NREG-bit register; bit set on lat_issue at lat_wreg, cleared on lat_done at lat_dreg; same index set and clear in one cycle -> set wins; different indices both take effect.
REQ-021 Scoreboard stall: a used D source whose bit is set, or a D instruction with regwrite_e... (WAW) i.e. lat_issue asserted while bit lat_wreg already set shall assert stall_e; the issue is not recorded.
REQ-022 stall_d = load-use | branch | scoreboard stall | stall_e; stall_f = stall_d.
REQ-023 flush_e shall assert when stall_d and not stall_e (bubble insertion).
REQ-024 Flush FSM states RUN, FLUSH; RUN->FLUSH on except_m, loading counter with FLUSH_CYC-1; FLUSH decrements, returns to RUN in the cycle after counter is 0; except_m in FLUSH reloads counter.
REQ-025 flush_f/d/e/m/w shall be 1 combinationally when except_m, and for all cycles in FLUSH; flush overrides: all stall outputs 0 while any flush-all is active.
REQ-026 Scoreboard is not cleared by exceptions; in-flight long-latency results still clear bits.
REQ-027 flush_m shall also assert when stall_e and not exception (E bubble into M).

Reset
REQ-028 On rst: scoreboard all 0, FSM RUN, counter 0; in the reset cycle all stall and flush outputs 0, forwards 00/0, scb_busy 0, flushing 0; rst overrides lat_issue/except_m.

Configuration
REQ-029 Macro HAZ_DIV_SCB_EN: defined -> divider tracked via scoreboard (REQ-020/021), div_busy only stalls E when lat_issue with div_busy; undefined -> scoreboard and lat_* ignored, scb_busy tied 0, stall_e = div_busy (whole front end stalls while divider busy).

Verification
REQ-030 lat_issue lat_wreg=8; next cycle rs_d=8 use_rs_d=1 -> stall_d=stall_f=1, flush_e=1 until lat_done lat_dreg=8, then stall_d=0 next cycle (macro defined).
REQ-031 memtoreg_e=1 wreg_e=5, rt_d=5 use_rt_d=1 -> stall_d=1, flush_e=1 one cycle; rt_d=0 -> no stall.
REQ-032 rs_e=3, wreg_m=3 regwrite_m=1, wreg_w=3 regwrite_w=1 -> fwd_a_e=10; drop regwrite_m -> 01.
REQ-033 FLUSH_CYC=3, except_m pulse during load-use stall -> all flushes 1 for 4 cycles (pulse + 3), stalls 0, flushing 1 for 3 cycles.
REQ-034 Same cycle lat_issue wreg=4 and lat_done dreg=4 with bit 4 clear -> bit 4 set, scb_busy=1; rst next cycle -> scb_busy=0.

Source files
------------

// File: rtl/pipe_hazard_scb.sv
// pipe_hazard_scb: hazard unit for a 5-stage RISC-V pipeline.
// It provides E/D forwarding selects, load-use, branch and scoreboard
// stalls, bubble flushes, and an exception flush FSM that holds the
// flushes for FLUSH_CYC cycles.
// Optional macro HAZ_DIV_SCB_EN tracks divider results in a per-register
// scoreboard. When the macro is not defined, div_busy stalls the whole
// front end.
// Ports: clk, rst (synchronous, active-high); D/E/M/W register indices
// and write flags; lat_* long-latency issue/done; div_busy; except_m;
// stall_*, flush_*, fwd_*, scb_busy and flushing outputs.
module pipe_hazard_scb #(
  parameter int REGW      = 5,
  parameter int FLUSH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic            use_rs_d,
  input  logic            use_rt_d,
  input  logic            branch_d,
  input  logic [REGW-1:0] rs_e,
  input  logic [REGW-1:0] rt_e,
  input  logic [REGW-1:0] wreg_e,
  input  logic            regwrite_e,
  input  logic            memtoreg_e,
  input  logic [REGW-1:0] wreg_m,
  input  logic            regwrite_m,
  input  logic            memtoreg_m,
  input  logic [REGW-1:0] wreg_w,
  input  logic            regwrite_w,
  input  logic            lat_issue,
  input  logic [REGW-1:0] lat_wreg,
  input  logic            lat_done,
  input  logic [REGW-1:0] lat_dreg,
  input  logic            div_busy,
  input  logic            except_m,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            flush_f,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            flush_w,
  output logic            fwd_a_d,
  output logic            fwd_b_d,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            scb_busy,
  output logic            flushing
);

  localparam int NREG = 2**REGW;
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYC - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state;
  logic [3:0] cnt;

  logic useRs, useRt;
  logic eHitRs, eHitRt, mHitRs, mHitRt;
  logic mWr, wWr;
  logic loadUse, brStall, scbStall, scbBusy;
  logic stallE, stallD, flushAll;
  logic [1:0] selA, selB;
  logic fwdDA, fwdDB;

  // A zero index never counts as a used source.
  assign useRs = use_rs_d && (rs_d != '0);
  assign useRt = use_rt_d && (rt_d != '0);

  assign eHitRs = useRs && (wreg_e == rs_d);
  assign eHitRt = useRt && (wreg_e == rt_d);
  assign mHitRs = useRs && (wreg_m == rs_d);
  assign mHitRt = useRt && (wreg_m == rt_d);

  assign loadUse = memtoreg_e && (eHitRs || eHitRt);
  assign brStall = branch_d &&
                   ((regwrite_e && (eHitRs || eHitRt)) ||
                    (memtoreg_m && (mHitRs || mHitRt)));

  assign mWr = regwrite_m && (wreg_m != '0);
  assign wWr = regwrite_w && (wreg_w != '0);

  assign selA = (mWr && wreg_m == rs_e) ? 2'b10 :
                (wWr && wreg_w == rs_e) ? 2'b01 : 2'b00;
  assign selB = (mWr && wreg_m == rt_e) ? 2'b10 :
                (wWr && wreg_w == rt_e) ? 2'b01 : 2'b00;

  // A load in M has no data yet, so it cannot forward to D.
  assign fwdDA = mWr && !memtoreg_m && (wreg_m == rs_d);
  assign fwdDB = mWr && !memtoreg_m && (wreg_m == rt_d);

`ifdef HAZ_DIV_SCB_EN
  logic [NREG-1:0] scb;
  logic [NREG-1:0] scbNext;

  // A second issue to a pending register (WAW), or an issue while the
  // divider is busy, holds E. The issue is retried and not recorded.
  assign stallE   = lat_issue && (div_busy || scb[lat_wreg]);
  assign scbStall = (useRs && scb[rs_d]) || (useRt && scb[rt_d]);
  assign scbBusy  = |scb;

  // The clear is applied first, so a set to the same index wins.
  always_comb begin
    scbNext = scb;
    if (lat_done)
      scbNext[lat_dreg] = 1'b0;
    if (lat_issue && !stallE && lat_wreg != '0)
      scbNext[lat_wreg] = 1'b1;
    scbNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) scb <= '0;
    else     scb <= scbNext;
  end
`else
  logic unusedLat;

  assign unusedLat = ^{lat_issue, lat_wreg, lat_done, lat_dreg};
  assign stallE    = div_busy;
  assign scbStall  = 1'b0;
  assign scbBusy   = 1'b0;
`endif

  assign stallD   = loadUse || brStall || scbStall || stallE;
  assign flushAll = except_m || (state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (except_m) begin
            state <= FLUSH;
            cnt   <= CNT_LOAD;
          end
        end
        FLUSH: begin
          if (except_m)        cnt   <= CNT_LOAD;
          else if (cnt == '0)  state <= RUN;
          else                 cnt   <= cnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_f  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_w  = 1'b0;
    fwd_a_d  = 1'b0;
    fwd_b_d  = 1'b0;
    fwd_a_e  = 2'b00;
    fwd_b_e  = 2'b00;
    scb_busy = 1'b0;
    flushing = 1'b0;
    if (!rst) begin
      fwd_a_d  = fwdDA;
      fwd_b_d  = fwdDB;
      fwd_a_e  = selA;
      fwd_b_e  = selB;
      scb_busy = scbBusy;
      flushing = (state == FLUSH);
      if (flushAll) begin
        {flush_f, flush_d, flush_e, flush_m, flush_w} = 5'b11111;
      end else begin
        stall_f = stallD;
        stall_d = stallD;
        stall_e = stallE;
        flush_e = stallD && !stallE;
        flush_m = stallE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scb.sv
// tb_pipe_hazard_scb: directed scenarios plus randomized traffic checked
// against a rule-level reference model of the hazard unit.
module tb_pipe_hazard_scb;

  localparam int REGW = 5;
  localparam int NREG = 32;
  localparam int FC   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REGW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic [REGW-1:0] lat_wreg, lat_dreg;
  logic use_rs_d, use_rt_d, branch_d;
  logic regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
  logic lat_issue, lat_done, div_busy, except_m;
  logic stall_f, stall_d, stall_e;
  logic flush_f, flush_d, flush_e, flush_m, flush_w;
  logic fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic scb_busy, flushing;

  int errors = 0;
  int checks = 0;

  bit mScb[NREG];
  int mLeft = 0;

  always #5 clk = ~clk;

  pipe_hazard_scb #(.REGW(REGW), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .branch_d(branch_d),
    .rs_e(rs_e), .rt_e(rt_e), .wreg_e(wreg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .wreg_m(wreg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .wreg_w(wreg_w), .regwrite_w(regwrite_w),
    .lat_issue(lat_issue), .lat_wreg(lat_wreg),
    .lat_done(lat_done), .lat_dreg(lat_dreg),
    .div_busy(div_busy), .except_m(except_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e),
    .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .scb_busy(scb_busy), .flushing(flushing)
  );

  // [15:13] stalls f/d/e, [12:8] flushes f..w, [7:6] fwd d,
  // [5:4] fwd_a_e, [3:2] fwd_b_e, [1] scb_busy, [0] flushing
  function automatic logic [15:0] dutVec();
    return {stall_f, stall_d, stall_e,
            flush_f, flush_d, flush_e, flush_m, flush_w,
            fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, scb_busy, flushing};
  endfunction

  function automatic logic [1:0] mFwdE(input logic [REGW-1:0] s);
    if (s == 0) return 2'b00;
    if (regwrite_m && wreg_m == s) return 2'b10;
    if (regwrite_w && wreg_w == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mStallE();
`ifdef HAZ_DIV_SCB_EN
    return lat_issue && (div_busy || mScb[lat_wreg]);
`else
    return div_busy;
`endif
  endfunction

  function automatic logic [15:0] model();
    logic [REGW-1:0] src [2];
    bit used [2];
    bit ld, br, sc, se, sd, busy, fad, fbd, inFl;
    if (rst) return 16'h0;
    src[0] = rs_d;  used[0] = use_rs_d;
    src[1] = rt_d;  used[1] = use_rt_d;
    ld = 0; br = 0; sc = 0; busy = 0;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && src[i] != 0) begin
        if (memtoreg_e && wreg_e == src[i]) ld = 1;
        if (branch_d && ((regwrite_e && wreg_e == src[i]) ||
                         (memtoreg_m && wreg_m == src[i]))) br = 1;
`ifdef HAZ_DIV_SCB_EN
        if (mScb[src[i]]) sc = 1;
`endif
      end
    end
    for (int k = 0; k < NREG; k++) if (mScb[k]) busy = 1;
    se   = mStallE();
    sd   = ld | br | sc | se;
    inFl = (mLeft > 0);
    fad  = rs_d != 0 && regwrite_m && !memtoreg_m && wreg_m == rs_d;
    fbd  = rt_d != 0 && regwrite_m && !memtoreg_m && wreg_m == rt_d;
    if (except_m || inFl)
      return {3'b000, 5'b11111, fad, fbd,
              mFwdE(rs_e), mFwdE(rt_e), busy, inFl};
    return {sd, sd, se, 1'b0, 1'b0, sd && !se, se, 1'b0,
            fad, fbd, mFwdE(rs_e), mFwdE(rt_e), busy, 1'b0};
  endfunction

  // Advance one clock and update the model from the inputs seen there.
  task automatic tick();
    bit se;
    se = mStallE();
    @(posedge clk);
    if (rst) begin
      foreach (mScb[k]) mScb[k] = 0;
      mLeft = 0;
    end else begin
      if (except_m) mLeft = FC;
      else if (mLeft > 0) mLeft--;
`ifdef HAZ_DIV_SCB_EN
      if (lat_done) mScb[lat_dreg] = 0;
      if (lat_issue && lat_wreg != 0 && !se) mScb[lat_wreg] = 1;
`endif
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; rs_d = 0; rt_d = 0; use_rs_d = 0; use_rt_d = 0;
    branch_d = 0; rs_e = 0; rt_e = 0; wreg_e = 0;
    regwrite_e = 0; memtoreg_e = 0; wreg_m = 0; regwrite_m = 0;
    memtoreg_m = 0; wreg_w = 0; regwrite_w = 0; lat_issue = 0;
    lat_wreg = 0; lat_done = 0; lat_dreg = 0; div_busy = 0;
    except_m = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    @(posedge clk); #1;
    lat_issue = 1; lat_wreg = 8; except_m = 1; div_busy = 1;
    memtoreg_e = 1; wreg_e = 5; rt_d = 5; use_rt_d = 1;
    regwrite_m = 1; wreg_m = 3; rs_e = 3;
    #2; checks++;
    if (dutVec() !== 16'h0) begin
      errors++;
      $display("FAIL reset_cycle got=%h exp=%h", dutVec(), 16'h0);
    end
    tick();
    idle(); #2; checks++;
    if (dutVec() !== 16'h0) begin
      errors++;
      $display("FAIL post_reset got=%h exp=%h", dutVec(), 16'h0);
    end
    tick();
  endtask

  task automatic test_fwd_e();
    idle(); rs_e = 3; wreg_m = 3; regwrite_m = 1;
    wreg_w = 3; regwrite_w = 1;
    #2; checks++;
    if (fwd_a_e !== 2'b10) begin
      errors++;
      $display("FAIL fwd_a_e_m got=%b exp=10", fwd_a_e);
    end
    tick();
    regwrite_m = 0;
    #2; checks++;
    if (fwd_a_e !== 2'b01) begin
      errors++;
      $display("FAIL fwd_a_e_w got=%b exp=01", fwd_a_e);
    end
    tick();
    idle(); wreg_m = 0; regwrite_m = 1;
    rt_e = 9; wreg_w = 9; regwrite_w = 1;
    #2; checks++;
    if ({fwd_a_e, fwd_b_e} !== 4'b0001) begin
      errors++;
      $display("FAIL fwd_r0_b_w got=%b exp=0001", {fwd_a_e, fwd_b_e});
    end
    tick();
  endtask

  task automatic test_fwd_d();
    idle(); rs_d = 6; rt_d = 6; wreg_m = 6; regwrite_m = 1;
    #2; checks++;
    if ({fwd_a_d, fwd_b_d} !== 2'b11) begin
      errors++;
      $display("FAIL fwd_d got=%b exp=11", {fwd_a_d, fwd_b_d});
    end
    tick();
    memtoreg_m = 1;
    #2; checks++;
    if ({fwd_a_d, fwd_b_d} !== 2'b00) begin
      errors++;
      $display("FAIL fwd_d_load got=%b exp=00", {fwd_a_d, fwd_b_d});
    end
    tick();
  endtask

  task automatic test_load_use();
    idle(); memtoreg_e = 1; wreg_e = 5; rt_d = 5; use_rt_d = 1;
    #2; checks++;
    if ({stall_f, stall_d, stall_e, flush_e, flush_m} !== 5'b11010) begin
      errors++;
      $display("FAIL load_use got=%b exp=11010",
               {stall_f, stall_d, stall_e, flush_e, flush_m});
    end
    tick();
    rt_d = 0;
    #2; checks++;
    if ({stall_d, flush_e} !== 2'b00) begin
      errors++;
      $display("FAIL load_use_r0 got=%b exp=00", {stall_d, flush_e});
    end
    tick();
    rt_d = 5; use_rt_d = 0;
    #2; checks++;
    if ({stall_d, flush_e} !== 2'b00) begin
      errors++;
      $display("FAIL load_use_unused got=%b exp=00", {stall_d, flush_e});
    end
    tick();
  endtask

  task automatic test_branch();
    idle(); branch_d = 1; rs_d = 7; use_rs_d = 1;
    regwrite_e = 1; wreg_e = 7;
    #2; checks++;
    if ({stall_d, flush_e} !== 2'b11) begin
      errors++;
      $display("FAIL branch_e got=%b exp=11", {stall_d, flush_e});
    end
    tick();
    regwrite_e = 0; memtoreg_m = 1; wreg_m = 7;
    #2; checks++;
    if ({stall_d, flush_e} !== 2'b11) begin
      errors++;
      $display("FAIL branch_m_load got=%b exp=11", {stall_d, flush_e});
    end
    tick();
    memtoreg_m = 0; regwrite_m = 1;
    #2; checks++;
    if ({stall_d, fwd_a_d} !== 2'b01) begin
      errors++;
      $display("FAIL branch_m_alu got=%b exp=01", {stall_d, fwd_a_d});
    end
    tick();
  endtask

  task automatic test_div();
`ifdef HAZ_DIV_SCB_EN
    idle(); lat_issue = 1; lat_wreg = 8;
    #2; checks++;
    if ({stall_d, stall_e, scb_busy} !== 3'b000) begin
      errors++;
      $display("FAIL issue got=%b exp=000", {stall_d, stall_e, scb_busy});
    end
    tick();
    idle(); rs_d = 8; use_rs_d = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin lat_done = 1; lat_dreg = 8; end
      #2; checks++;
      if ({stall_f, stall_d, stall_e, flush_e, scb_busy} !== 5'b11011) begin
        errors++;
        $display("FAIL scb_raw[%0d] got=%b exp=11011", i,
                 {stall_f, stall_d, stall_e, flush_e, scb_busy});
      end
      tick();
    end
    lat_done = 0;
    #2; checks++;
    if ({stall_d, flush_e, scb_busy} !== 3'b000) begin
      errors++;
      $display("FAIL scb_clear got=%b exp=000", {stall_d, flush_e, scb_busy});
    end
    tick();
    idle(); lat_issue = 1; lat_wreg = 4; lat_done = 1; lat_dreg = 4;
    tick();
    idle(); rs_d = 4; use_rs_d = 1;
    #2; checks++;
    if ({stall_d, scb_busy} !== 2'b11) begin
      errors++;
      $display("FAIL set_wins got=%b exp=11", {stall_d, scb_busy});
    end
    tick();
    idle(); lat_issue = 1; lat_wreg = 4;
    #2; checks++;
    if ({stall_e, stall_d, flush_e, flush_m} !== 4'b1101) begin
      errors++;
      $display("FAIL waw got=%b exp=1101",
               {stall_e, stall_d, flush_e, flush_m});
    end
    tick();
    idle(); lat_issue = 1; lat_wreg = 10; lat_done = 1; lat_dreg = 4;
    tick();
    idle(); rs_d = 4; use_rs_d = 1;
    #2; checks++;
    if (stall_d !== 1'b0) begin
      errors++;
      $display("FAIL diff_clear got=%b exp=0", stall_d);
    end
    tick();
    rs_d = 10;
    #2; checks++;
    if (stall_d !== 1'b1) begin
      errors++;
      $display("FAIL diff_set got=%b exp=1", stall_d);
    end
    tick();
    idle(); lat_issue = 1; lat_wreg = 12; div_busy = 1;
    #2; checks++;
    if (stall_e !== 1'b1) begin
      errors++;
      $display("FAIL issue_busy got=%b exp=1", stall_e);
    end
    tick();
    idle(); rst = 1;
    #2; checks++;
    if (scb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got=%b exp=0", scb_busy);
    end
    tick();
    idle(); rs_d = 10; use_rs_d = 1; rt_d = 12; use_rt_d = 1;
    #2; checks++;
    if ({stall_d, scb_busy} !== 2'b00) begin
      errors++;
      $display("FAIL after_rst got=%b exp=00", {stall_d, scb_busy});
    end
    tick();
`else
    idle(); div_busy = 1;
    #2; checks++;
    if ({stall_f, stall_d, stall_e, flush_e, flush_m} !== 5'b11101) begin
      errors++;
      $display("FAIL div_busy got=%b exp=11101",
               {stall_f, stall_d, stall_e, flush_e, flush_m});
    end
    tick();
    idle(); lat_issue = 1; lat_wreg = 8;
    tick();
    idle(); rs_d = 8; use_rs_d = 1;
    #2; checks++;
    if ({stall_d, scb_busy} !== 2'b00) begin
      errors++;
      $display("FAIL lat_ignored got=%b exp=00", {stall_d, scb_busy});
    end
    tick();
`endif
  endtask

  task automatic test_flush();
    idle(); memtoreg_e = 1; wreg_e = 5; rt_d = 5; use_rt_d = 1;
    except_m = 1;
    #2; checks++;
    if (dutVec() !== 16'h1F00) begin
      errors++;
      $display("FAIL flush_pulse got=%h exp=%h", dutVec(), 16'h1F00);
    end
    tick();
    except_m = 0;
    for (int i = 0; i < FC; i++) begin
      #2; checks++;
      if (dutVec() !== 16'h1F01) begin
        errors++;
        $display("FAIL flush_hold[%0d] got=%h exp=%h", i, dutVec(), 16'h1F01);
      end
      tick();
    end
    #2; checks++;
    if (dutVec() !== 16'hC400) begin
      errors++;
      $display("FAIL flush_release got=%h exp=%h", dutVec(), 16'hC400);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 79) == 0);
      rs_d       = REGW'($urandom_range(0, 7));
      rt_d       = REGW'($urandom_range(0, 7));
      use_rs_d   = 1'($urandom);
      use_rt_d   = 1'($urandom);
      branch_d   = ($urandom_range(0, 3) == 0);
      rs_e       = REGW'($urandom_range(0, 7));
      rt_e       = REGW'($urandom_range(0, 7));
      wreg_e     = REGW'($urandom_range(0, 7));
      regwrite_e = 1'($urandom);
      memtoreg_e = ($urandom_range(0, 2) == 0);
      wreg_m     = REGW'($urandom_range(0, 7));
      regwrite_m = 1'($urandom);
      memtoreg_m = ($urandom_range(0, 2) == 0);
      wreg_w     = REGW'($urandom_range(0, 7));
      regwrite_w = 1'($urandom);
      lat_issue  = ($urandom_range(0, 3) == 0);
      lat_wreg   = REGW'($urandom_range(0, 7));
      lat_done   = ($urandom_range(0, 3) == 0);
      lat_dreg   = REGW'($urandom_range(0, 7));
      div_busy   = ($urandom_range(0, 7) == 0);
      except_m   = ($urandom_range(0, 39) == 0);
      #2;
      exp = model();
      checks++;
      if (dutVec() !== exp) begin
        errors++;
        $display("FAIL random[%0d] got=%h exp=%h", n, dutVec(), exp);
      end
      tick();
    end
    idle(); rst = 1;
    tick();
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_fwd_e();
    test_fwd_d();
    test_load_use();
    test_branch();
    test_div();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
